// File: rtl/seq_alu_md.sv
// seq_alu_md: RV32I ALU with one-cycle latency plus iterative RV32M multiply/divide behind valid/ready.
module seq_alu_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            md,
    input  logic [3:0]      alu_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MULT, DIVD, DONE} state_t;
    state_t          state_q;
    logic [SW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic            neg_q, rneg_q, zero_q;
    logic [XLEN-1:0] m_q, result_q;
    logic [2*XLEN-1:0] prod_q;
    logic            acc, sgn_a, sgn_b, a_neg, b_neg, spec;
    logic [XLEN-1:0] ma, mb, spec_res, base_res, acc_res;
    logic [XLEN:0]   mul_sum, div_tr;
    logic [2*XLEN-1:0] mul_nx, div_nx, mul_full;
    logic [XLEN-1:0] q_mag, r_mag, q_fix, r_fix, mul_res, div_res, iter_res;
    assign busy       = (state_q == MULT) || (state_q == DIVD);
    assign out_valid  = state_q == DONE;
    assign in_ready   = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign acc        = in_valid && in_ready;
    assign alu_result = result_q;
    assign zero       = zero_q;
    // Operands are iterated as magnitudes; the recorded signs fix up the final result.
    assign sgn_a    = alu_ctrl[2] ? !alu_ctrl[0] : (alu_ctrl[1] ^ alu_ctrl[0]);
    assign sgn_b    = alu_ctrl[2] ? !alu_ctrl[0] : (alu_ctrl[1:0] == 2'b01);
    assign a_neg    = sgn_a && op1[XLEN-1];
    assign b_neg    = sgn_b && op2[XLEN-1];
    assign ma       = a_neg ? -op1 : op1;
    assign mb       = b_neg ? -op2 : op2;
    assign spec     = md && alu_ctrl[2] && ((op2 == '0) ||
                      (!alu_ctrl[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&op2)));
    assign spec_res = (op2 == '0) ? (alu_ctrl[1] ? op1 : '1) : (alu_ctrl[1] ? '0 : op1);
    always_comb begin
        base_res = '0;
        case (alu_ctrl)
            4'b0000: base_res = op1 + op2;
            4'b1000: base_res = op1 - op2;
            4'b0001: base_res = op1 << op2[SW-1:0];
            4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'b0011: base_res = {{(XLEN-1){1'b0}}, op1 < op2};
            4'b0100: base_res = op1 ^ op2;
            4'b0101: base_res = op1 >> op2[SW-1:0];
            4'b1101: base_res = $unsigned($signed(op1) >>> op2[SW-1:0]);
            4'b0110: base_res = op1 | op2;
            4'b0111: base_res = op1 & op2;
            default: base_res = '0;
        endcase
    end
    assign acc_res  = spec ? spec_res : base_res;
    // prod_q holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIVD.
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, m_q} : '0);
    assign mul_nx   = {mul_sum, prod_q[XLEN-1:1]};
    assign div_tr   = prod_q[2*XLEN-1:XLEN-1] - {1'b0, m_q};
    assign div_nx   = div_tr[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0}
                                   : {div_tr[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    assign mul_full = neg_q ? -mul_nx : mul_nx;
    assign mul_res  = (op_q == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    assign q_mag    = div_nx[XLEN-1:0];
    assign r_mag    = div_nx[2*XLEN-1:XLEN];
    assign q_fix    = neg_q ? -q_mag : q_mag;
    assign r_fix    = rneg_q ? -r_mag : r_mag;
    assign div_res  = op_q[1] ? r_fix : q_fix;
    assign iter_res = (state_q == MULT) ? mul_res : div_res;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            m_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (acc) begin
            op_q   <= alu_ctrl[1:0];
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= '0;
            if (!md || spec) begin
                state_q  <= DONE;
                result_q <= acc_res;
                zero_q   <= acc_res == '0;
            end else if (!alu_ctrl[2]) begin
                state_q <= MULT;
                m_q     <= ma;
                prod_q  <= {{XLEN{1'b0}}, mb};
            end else begin
                state_q <= DIVD;
                m_q     <= mb;
                prod_q  <= {{XLEN{1'b0}}, ma};
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
        end else if (busy) begin
            prod_q <= (state_q == MULT) ? mul_nx : div_nx;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == SW'(XLEN-1)) begin
                state_q  <= DONE;
                result_q <= iter_res;
                zero_q   <= iter_res == '0;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu_md.sv
// tb_seq_alu_md: directed and randomized checks of seq_alu_md against an arithmetic reference model.
module tb_seq_alu_md;
    localparam logic [31:0] MIN = 32'h8000_0000;
    logic        clk = 1'b0, reset, in_valid, in_ready, md, out_valid, out_ready, zero, busy;
    logic [31:0] op1, op2, alu_result;
    logic [3:0]  alu_ctrl;
    int          total = 0, bad = 0;

    seq_alu_md #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .md(md), .alu_ctrl(alu_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic m, input logic [3:0] c,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (!m) begin
            case (c)
                4'd0:  return a + b;
                4'd8:  return a - b;
                4'd1:  return 32'(ua * (64'd1 << b[4:0]));
                4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
                4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
                4'd4:  return a ^ b;
                4'd5:  return 32'(ua / (64'd1 << b[4:0]));
                4'd13: begin p = 64'(sa >>> b[4:0]); return p[31:0]; end
                4'd6:  return a | b;
                4'd7:  return a & b;
                default: return 32'd0;
            endcase
        end
        case (c[2:0])
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic m, input logic [3:0] c,
                                   input logic [31:0] a, input logic [31:0] b);
        if (!m) return 1;
        if (c[2] && (b == 0 || (!c[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic m, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n, bc;
        @(negedge clk);
        md = m; alu_ctrl = c; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, ".rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; md = 1'($urandom); alu_ctrl = 4'($urandom);
        n = 1;
        bc = 0;
        while (!out_valid && n < 40) begin
            bc += int'(busy);
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".res"}, alu_result, exp);
        chk({tag, ".zero"}, zero, exp == 0);
        chk({tag, ".busycyc"}, bc, lat - 1);
        chk({tag, ".busyend"}, busy, 0);
    endtask

    initial begin
        logic seen;
        logic m;
        logic [3:0] c;
        logic [31:0] a, b;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; md = 1'b0;
        alu_ctrl = 4'd0; op1 = 32'd0; op2 = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst.rdy", in_ready, 0);
        chk("rst.valid", out_valid, 0);
        chk("rst.res", alu_result, 0);
        chk("rst.zero", zero, 1);
        chk("rst.busy", busy, 0);
        reset = 1'b0;
        #1 chk("rst.rdy_after", in_ready, 1);

        run_op("add",  0, 4'b0000, 32'h75, 32'h39, 32'hAE, 1);
        run_op("sub",  0, 4'b1000, 32'h75, 32'h39, 32'h3C, 1);
        run_op("sll",  0, 4'b0001, 32'h75, 32'h39, 32'hEA00_0000, 1);
        run_op("slt",  0, 4'b0010, 32'h75, 32'h39, 32'h0, 1);
        run_op("sltu", 0, 4'b0011, 32'h75, 32'h39, 32'h0, 1);
        run_op("xor",  0, 4'b0100, 32'h75, 32'h39, 32'h4C, 1);
        run_op("srl",  0, 4'b0101, 32'h75, 32'h39, 32'h0, 1);
        run_op("sra",  0, 4'b1101, 32'h75, 32'h39, 32'h0, 1);
        run_op("or",   0, 4'b0110, 32'h75, 32'h39, 32'h7D, 1);
        run_op("and",  0, 4'b0111, 32'h75, 32'h39, 32'h31, 1);
        run_op("mulhu", 1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul",   1, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33);
        run_op("div",   1, 4'b0100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
        run_op("rem",   1, 4'b0110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
        run_op("divu",  1, 4'b0101, 32'h75, 32'h39, 32'h2, 33);
        run_op("remu",  1, 4'b0111, 32'h75, 32'h39, 32'h3, 33);
        run_op("divu0", 1, 4'b0101, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("remu0", 1, 4'b0111, 32'h5, 32'h0, 32'h5, 1);
        run_op("divov", 1, 4'b0100, MIN, 32'hFFFF_FFFF, MIN, 1);
        run_op("remov", 1, 4'b0110, MIN, 32'hFFFF_FFFF, 32'h0, 1);

        @(negedge clk);
        md = 1'b0; alu_ctrl = 4'b0000; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        op1 = 32'd10; op2 = 32'd20;
        for (int i = 0; i < 3; i++) begin
            chk("bp.valid", out_valid, 1);
            chk("bp.res", alu_result, 32'd7);
            chk("bp.rdy", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp.reaccept_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.b2b_valid", out_valid, 1);
        chk("bp.b2b_res", alu_result, 32'd30);
        @(negedge clk);
        chk("bp.drain", out_valid, 0);

        @(negedge clk);
        md = 1'b1; alu_ctrl = 4'b0100; op1 = 32'hFFFF_FFF9; op2 = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("ra.busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ra.valid", out_valid, 0);
        chk("ra.res", alu_result, 0);
        chk("ra.zero", zero, 1);
        chk("ra.busy", busy, 0);
        chk("ra.rdy", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("ra.no_valid", seen, 0);
        run_op("ra.add", 0, 4'b0000, 32'd1, 32'd1, 32'd2, 1);

        for (int i = 0; i < 60; i++) begin
            m = 1'($urandom);
            c = 4'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = MIN; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 9);
                3: a = $urandom_range(0, 3);
                default: ;
            endcase
            run_op("rnd", m, c, a, b, ref_alu(m, c, a, b), ref_lat(m, c, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
